// File: rtl/hash_jtree_stream.sv
// hash_jtree_stream: XOR-fold hash jitter on the sub-pixel bits of LANES sample
// positions per group. Triangle, colour and lane-valid bits ride along through
// an elastic valid/ready pipeline of PIPE_DEPTH stages.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   tri_in/color_in           triangle / colour, passed unmodified
//   sample_in                 [0]=x, [1]=y per lane, jittered before stage 0
//   validSamp_in              per-lane valid, passed unmodified
//   in_valid/in_ready         input handshake (in_ready is combinational)
//   subSample_RnnnnU          MSAA select, highest set bit picks the jitter mask
//   jitter_en                 0 passes samples bit-exact
//   *_out, out_valid/out_ready output group and handshake
//   group_cnt                 saturating count of output transfers
module hash_jtree_stream #(
    parameter int unsigned SIGFIG     = 24,
    parameter int unsigned RADIX      = 10,
    parameter int unsigned VERTS      = 3,
    parameter int unsigned AXIS       = 3,
    parameter int unsigned COLORS     = 3,
    parameter int unsigned LANES      = 4,
    parameter int unsigned PIPE_DEPTH = 2,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]    tri_in,
    input  logic [COLORS-1:0][SIGFIG-1:0]             color_in,
    input  logic [1:0][LANES-1:0][SIGFIG-1:0]         sample_in,
    input  logic [LANES-1:0]                          validSamp_in,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [3:0]                                subSample_RnnnnU,
    input  logic                                      jitter_en,
    output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]    tri_out,
    output logic [COLORS-1:0][SIGFIG-1:0]             color_out,
    output logic [1:0][LANES-1:0][SIGFIG-1:0]         sample_out,
    output logic [LANES-1:0]                          validSamp_out,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [CNT_W-1:0]                          group_cnt
);

    localparam int unsigned HJ = RADIX - 2;      // jitter width
    localparam int unsigned SW = SIGFIG - 4;     // coordinate bits fed to the hash
    localparam int unsigned HW = 2 * SW;         // hash input width
    localparam logic [HJ-1:0] ONES = '1;

    // XOR of consecutive HJ-bit chunks, last chunk implicitly zero-padded
    function automatic logic [HJ-1:0] fold(input logic [HW-1:0] v);
        logic [HJ-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < HW; i++) begin
            acc[i % HJ] = acc[i % HJ] ^ v[i];
        end
        return acc;
    endfunction

    logic [HJ-1:0]                       mask_c;
    logic [SW-1:0]                       xs_c, ys_c;
    logic [HJ-1:0]                       jx_c, jy_c;
    logic [1:0][LANES-1:0][SIGFIG-1:0]   samp_jit_c;

    // Mask select (highest set bit wins) and per-lane jitter, using the
    // config present at input transfer so each group carries its own setting
    always_comb begin
        mask_c     = '0;
        xs_c       = '0;
        ys_c       = '0;
        jx_c       = '0;
        jy_c       = '0;
        samp_jit_c = sample_in;
        if (subSample_RnnnnU[0]) mask_c = ONES >> 3;
        if (subSample_RnnnnU[1]) mask_c = ONES >> 2;
        if (subSample_RnnnnU[2]) mask_c = ONES >> 1;
        if (subSample_RnnnnU[3]) mask_c = ONES;
        for (int unsigned l = 0; l < LANES; l++) begin
            xs_c = sample_in[0][l][SIGFIG-1:4];
            ys_c = sample_in[1][l][SIGFIG-1:4];
            jx_c = fold({ys_c, xs_c}) & mask_c;
            jy_c = fold({xs_c, ys_c}) & mask_c;
            if (jitter_en) begin
                samp_jit_c[0][l] = sample_in[0][l] | (SIGFIG'(jx_c) << 2);
                samp_jit_c[1][l] = sample_in[1][l] | (SIGFIG'(jy_c) << 2);
            end
        end
    end

    logic [PIPE_DEPTH-1:0]                   v_q;
    logic [PIPE_DEPTH-1:0]                   ld_c;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_q   [PIPE_DEPTH];
    logic [COLORS-1:0][SIGFIG-1:0]           color_q [PIPE_DEPTH];
    logic [1:0][LANES-1:0][SIGFIG-1:0]       samp_q  [PIPE_DEPTH];
    logic [LANES-1:0]                        vs_q    [PIPE_DEPTH];
    logic [CNT_W-1:0]                        group_cnt_q;

    // Stage k may load when out_ready is high or any stage from k onward is
    // empty; written in closed form to keep the ready chain free of feedback
    always_comb begin
        ld_c = '0;
        for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
            ld_c[k] = out_ready;
            for (int unsigned j = k; j < PIPE_DEPTH; j++) begin
                if (!v_q[j]) ld_c[k] = 1'b1;
            end
        end
    end

    assign in_ready = ld_c[0];

    // Pipeline shift and saturating output-transfer counter
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q         <= '0;
            group_cnt_q <= '0;
            for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
                tri_q[k]   <= '0;
                color_q[k] <= '0;
                samp_q[k]  <= '0;
                vs_q[k]    <= '0;
            end
        end else begin
            if (ld_c[0]) begin
                v_q[0]     <= in_valid;
                tri_q[0]   <= tri_in;
                color_q[0] <= color_in;
                samp_q[0]  <= samp_jit_c;
                vs_q[0]    <= validSamp_in;
            end
            for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
                if (ld_c[k]) begin
                    v_q[k]     <= v_q[k-1];
                    tri_q[k]   <= tri_q[k-1];
                    color_q[k] <= color_q[k-1];
                    samp_q[k]  <= samp_q[k-1];
                    vs_q[k]    <= vs_q[k-1];
                end
            end
            if (v_q[PIPE_DEPTH-1] && out_ready && (group_cnt_q != '1)) begin
                group_cnt_q <= group_cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_valid     = v_q[PIPE_DEPTH-1];
    assign tri_out       = tri_q[PIPE_DEPTH-1];
    assign color_out     = color_q[PIPE_DEPTH-1];
    assign sample_out    = samp_q[PIPE_DEPTH-1];
    assign validSamp_out = vs_q[PIPE_DEPTH-1];
    assign group_cnt     = group_cnt_q;

endmodule

// File: tb/tb_hash_jtree_stream.sv
// Directed bench for hash_jtree_stream: jitter values, mask priority, bypass,
// backpressure streaming, per-group config capture, reset mid-stall and
// counter saturation (second instance with CNT_W=4).
module tb_hash_jtree_stream;

    localparam int unsigned SIGFIG = 24;
    localparam int unsigned VERTS  = 3;
    localparam int unsigned AXIS   = 3;
    localparam int unsigned COLORS = 3;
    localparam int unsigned LANES  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                                   rst;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_in, tri_out, tri_out2;
    logic [COLORS-1:0][SIGFIG-1:0]          color_in, color_out, color_out2;
    logic [1:0][LANES-1:0][SIGFIG-1:0]      sample_in, sample_out, sample_out2;
    logic [LANES-1:0]                       validSamp_in, validSamp_out, validSamp_out2;
    logic                                   in_valid, in_ready, in_ready2;
    logic [3:0]                             subSample;
    logic                                   jitter_en;
    logic                                   out_valid, out_valid2, out_ready;
    logic [31:0]                            group_cnt;
    logic [3:0]                             group_cnt2;

    int total = 0;
    int bad   = 0;

    hash_jtree_stream dut (
        .clk(clk), .rst(rst),
        .tri_in(tri_in), .color_in(color_in), .sample_in(sample_in),
        .validSamp_in(validSamp_in), .in_valid(in_valid), .in_ready(in_ready),
        .subSample_RnnnnU(subSample), .jitter_en(jitter_en),
        .tri_out(tri_out), .color_out(color_out), .sample_out(sample_out),
        .validSamp_out(validSamp_out), .out_valid(out_valid), .out_ready(out_ready),
        .group_cnt(group_cnt)
    );

    hash_jtree_stream #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .tri_in(tri_in), .color_in(color_in), .sample_in(sample_in),
        .validSamp_in(validSamp_in), .in_valid(in_valid), .in_ready(in_ready2),
        .subSample_RnnnnU(subSample), .jitter_en(jitter_en),
        .tri_out(tri_out2), .color_out(color_out2), .sample_out(sample_out2),
        .validSamp_out(validSamp_out2), .out_valid(out_valid2), .out_ready(out_ready),
        .group_cnt(group_cnt2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Send one group (samples already on sample_in) and wait for it at the output
    task automatic run_group(input logic [3:0] sub, input logic je, output int lat);
        @(negedge clk);
        subSample = sub;
        jitter_en = je;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) in_valid = 1'b0;
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) chk("out_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          sent, rcv, occ, nrec;
        logic        held, saw_full;
        logic [23:0] held_x;
        logic [23:0] got_x [2];

        rst          = 1'b1;
        tri_in       = '0;
        color_in     = '0;
        sample_in    = '0;
        validSamp_in = '0;
        in_valid     = 1'b0;
        subSample    = 4'b0000;
        jitter_en    = 1'b0;
        out_ready    = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_cnt", group_cnt, 0);
        rst = 1'b0;

        // Jitter values, latency and pass-through fields
        tri_in[0][0]    = 24'h123456;
        color_in[2]     = 24'hABCDEF;
        validSamp_in    = 4'b1011;
        sample_in[0][0] = 24'h000400; sample_in[1][0] = 24'h000000;
        sample_in[0][1] = 24'h000000; sample_in[1][1] = 24'h000000;
        sample_in[0][2] = 24'h000010; sample_in[1][2] = 24'h000020;
        sample_in[0][3] = 24'hFFFFFF; sample_in[1][3] = 24'hFFFFFF;
        run_group(4'b1000, 1'b1, lat);
        chk("latency", lat, 2);
        chk("m8_x0", sample_out[0][0], 24'h000500);
        chk("m8_y0", sample_out[1][0], 24'h000010);
        chk("m8_x1", sample_out[0][1], 24'h000000);
        chk("m8_y1", sample_out[1][1], 24'h000000);
        chk("m8_x2", sample_out[0][2], 24'h000094);
        chk("m8_y2", sample_out[1][2], 24'h000068);
        chk("m8_x3", sample_out[0][3], 24'hFFFFFF);
        chk("m8_y3", sample_out[1][3], 24'hFFFFFF);
        chk("vs_pass", validSamp_out, 4'b1011);
        chk("tri_pass", tri_out[0][0], 24'h123456);
        chk("col_pass", color_out[2], 24'hABCDEF);

        run_group(4'b0001, 1'b1, lat);
        chk("m1_x0", sample_out[0][0], 24'h000400);
        chk("m1_y0", sample_out[1][0], 24'h000010);
        chk("m1_x2", sample_out[0][2], 24'h000014);
        chk("m1_y2", sample_out[1][2], 24'h000068);

        run_group(4'b1000, 1'b0, lat);
        chk("byp_x0", sample_out[0][0], 24'h000400);
        chk("byp_y0", sample_out[1][0], 24'h000000);
        chk("byp_x2", sample_out[0][2], 24'h000010);
        chk("byp_y2", sample_out[1][2], 24'h000020);

        run_group(4'b0000, 1'b1, lat);
        chk("m0_x0", sample_out[0][0], 24'h000400);
        chk("m0_y0", sample_out[1][0], 24'h000000);

        run_group(4'b0110, 1'b1, lat);
        chk("m6_x0", sample_out[0][0], 24'h000500);
        chk("m6_y0", sample_out[1][0], 24'h000010);

        run_group(4'b0011, 1'b1, lat);
        chk("m3_x0", sample_out[0][0], 24'h000400);
        chk("m3_x2", sample_out[0][2], 24'h000094);

        // Config change while a group is in flight
        do_reset();
        out_ready = 1'b1;
        jitter_en = 1'b1;
        subSample = 4'b1000;
        in_valid  = 1'b1;
        @(negedge clk);
        subSample = 4'b0001;
        @(negedge clk);
        in_valid = 1'b0;
        nrec = 0;
        for (int c = 0; c < 10 && nrec < 2; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (out_valid && out_ready) begin
                got_x[nrec] = sample_out[0][0];
                nrec++;
            end
        end
        chk("cfg_count", nrec, 2);
        chk("cfg_first_x", got_x[0], 24'h000500);
        chk("cfg_second_x", got_x[1], 24'h000400);

        // Reset during a stall with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("stall_full_ov", out_valid, 1);
        chk("stall_full_ir", in_ready, 0);
        chk("pre_rst_cnt", group_cnt, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_cnt", group_cnt, 0);
        chk("mrst_samp", (sample_out == '0), 1);
        chk("mrst_vs", validSamp_out, 0);
        chk("mrst_tri", (tri_out == '0), 1);
        chk("mrst_col", (color_out == '0), 1);

        // Stream 8 groups with out_ready low on cycles 3-6
        jitter_en = 1'b0;
        sample_in = '0;
        sent = 0; rcv = 0; occ = 0;
        held = 1'b0; saw_full = 1'b0; held_x = '0;
        for (int c = 0; c < 60 && rcv < 8; c++) begin
            @(negedge clk);
            out_ready       = !(c >= 3 && c <= 6);
            in_valid        = (sent < 8);
            sample_in[0][0] = 24'(32'h100 + sent);
            sample_in[1][0] = 24'(32'h200 + sent);
            #1;
            chk("str_in_ready", in_ready, (occ < 2) || out_ready);
            if (!in_ready) saw_full = 1'b1;
            if (held) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_x", sample_out[0][0], held_x);
            end
            held   = out_valid && !out_ready;
            held_x = sample_out[0][0];
            if (out_valid && out_ready) begin
                chk("order_x", sample_out[0][0], 24'(32'h100 + rcv));
                chk("order_y", sample_out[1][0], 24'(32'h200 + rcv));
                rcv++;
                occ--;
            end
            if (in_valid && in_ready) begin
                sent++;
                occ++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("str_saw_full", saw_full, 1);
        chk("str_rcv", rcv, 8);
        chk("str_cnt", group_cnt, 8);
        chk("str_after_ov", out_valid, 0);

        // Saturation with CNT_W=4
        do_reset();
        out_ready = 1'b1;
        sent = 0; rcv = 0;
        for (int c = 0; c < 60 && rcv < 20; c++) begin
            @(negedge clk);
            in_valid = (sent < 20);
            #1;
            if (out_valid && out_ready) begin
                if (rcv == 15) chk("sat_at15", group_cnt2, 15);
                rcv++;
            end
            if (in_valid && in_ready) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("sat_rcv", rcv, 20);
        chk("sat_hold", group_cnt2, 15);
        chk("sat_wide_cnt", group_cnt, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hash_jtree_stream.md
Name: hash_jtree_stream

Overview:
- Parametrised successor of the fixed 4-lane jitter hash stage. It sits between sample test generation (R14) and the sample test (R16+).
- Computes an XOR-fold hash jitter for LANES sample positions per group and ORs the jitter into the sub-pixel bits.
- Carries the triangle and colour alongside each group.
- Adds a valid/ready elastic pipeline with backpressure, a jitter-bypass mode, per-group captured configuration, and a saturating accepted-group counter.

Parameters:
- SIGFIG, 24, fixed-point word width
- RADIX, 10, fractional bits; jitter width HJ = RADIX-2
- VERTS, 3, triangle vertices
- AXIS, 3, coordinates per vertex
- COLORS, 3, colour channels
- LANES, 4, samples per group (1..16)
- PIPE_DEPTH, 2, register stages input->output (>=1)
- CNT_W, 32, group-counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- tri_in  in  [VERTS][AXIS]xSIGFIG signed  triangle
- color_in  in  [COLORS]xSIGFIG unsigned  colour
- sample_in  in  [2][LANES]xSIGFIG signed  sample x ([0]) / y ([1])
- validSamp_in  in  [LANES]x1  per-lane valid
- in_valid  in  1  group present
- in_ready  out  1  stage can accept
- subSample_RnnnnU  in  4  one-hot MSAA select
- jitter_en  in  1  0 = bypass (no jitter)
- tri_out / color_out / sample_out / validSamp_out  out  same shapes as the inputs
- out_valid  out  1  output group present
- out_ready  in  1  downstream accepts
- group_cnt  out  CNT_W  accepted groups, saturating

Behaviour:
- Transfer: input on in_valid&&in_ready; output on out_valid&&out_ready.
- Elastic pipeline: stage k holds a valid bit. It loads when empty or when stage k+1 (or the output for the last stage) takes its contents.
  - in_ready = !v[0] || stage 0 advancing; combinational from out_ready through the stage chain.
  - No bubbles: full throughput at 1 group/cycle while out_ready=1.
  - Latency exactly PIPE_DEPTH cycles from input transfer to out_valid when unstalled.
  - Held outputs stay stable while out_valid && !out_ready.
- Config capture: subSample_RnnnnU and jitter_en are sampled on input transfer and applied to that group only. Changing them mid-flight does not affect in-flight groups.
- Mask M (HJ bits), highest set bit wins:
  - [3] -> all ones
  - [2] -> ones>>1
  - [1] -> ones>>2
  - [0] -> ones>>3
  - 0000 -> M=0
  - Non-one-hot inputs are legal; the priority rule above applies and no assertion fires.
- Hash per lane i:
  - Let xs = x[SIGFIG-1:4] and ys = y[SIGFIG-1:4].
  - hx input = {ys, xs}; hy input = {xs, ys}; both are 2*(SIGFIG-4) bits.
  - fold(v) = XOR of consecutive HJ-bit chunks of v, LSB-first, with the last chunk zero-padded.
  - jx = fold(hx)&M; jy = fold(hy)&M.
- Jitter application:
  - x_out = x | (jx << 2); y_out = y | (jy << 2).
  - Only bits [RADIX-1:2] can change; bits [SIGFIG-1:RADIX] and [1:0] are preserved.
  - With jitter_en=0 the sample passes bit-exact.
- Hash/OR is computed combinationally before stage 0 and registered into stage 0. tri, color and validSamp pass unmodified.
- Lanes with validSamp=0 are still hashed and passed; their valid bit stays 0.
- group_cnt increments on each output transfer and saturates at all ones (no wrap).
- Reset (any cycle, including mid-stall): all v[k]=0, out_valid=0, in_ready=1 from the next cycle, group_cnt=0, all data outputs 0, validSamp_out all 0. In-flight groups are discarded.
- Simultaneous input and output transfer with a full pipeline: the shift occurs and occupancy is unchanged.

Test Plan:
- Defaults; x=0x000400, y=0, subSample=1000, jitter_en=1, out_ready=1 -> after 2 cycles out_valid=1, x_out=0x000500, y_out=0x000010.
- Same sample with subSample=0001 -> x_out=0x000400 (jx=0x40&0x1F=0), y_out=0x000010. With jitter_en=0 -> x_out=0x000400, y_out=0x000000.
- Stream 8 groups with out_ready low for cycles 3-6:
  - in_ready drops once both stages are full.
  - Held output is stable during the stall.
  - All 8 groups arrive in order with no loss or duplication.
  - group_cnt=8.
- Change subSample 1000->0001 while a group is in flight -> the in-flight group is jittered with mask 0xFF, the next group with 0x1F.
- Assert rst during a stall with 2 valid stages -> next cycle out_valid=0, in_ready=1, group_cnt=0, outputs 0.
- CNT_W=4, stream 20 groups -> group_cnt reaches 15 and holds at 15.
